score_tracker: RTL and testbench

SCORE_TRACKER -- requirements
Module: score_tracker

---
 rtl/score_tracker.sv | 164 ++++++++++++++++
 tb/tb_score_tracker.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker
// Description : BCD score/high-score/elapsed-time tracker for the apple game.
// Revision    : 1.0  initial release
// ============================================================================
module score_tracker #(
   parameter int                  NUM_CH       = 5,
   parameter logic [4*NUM_CH-1:0] CH_WEIGHTS   = 20'h11311,
   parameter int                  SCORE_DIGITS = 4,
   parameter int                  TIME_DIGITS  = 4,
   parameter int                  CLK_HZ       = 100_000_000,
   parameter int                  PEND_W       = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         apple_hit,
   input  logic [1:0]                game_status,
   output logic [4*SCORE_DIGITS-1:0] score_bcd,
   output logic [4*SCORE_DIGITS-1:0] high_bcd,
   output logic [4*TIME_DIGITS-1:0]  time_bcd,
   output logic                      busy,
   output logic                      new_record,
   output logic                      sec_tick
);

   localparam int c_SUM_W  = 8;
   localparam int c_PSUM_W = PEND_W + c_SUM_W;
   localparam int c_PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [c_PRE_W-1:0]        c_PRE_MAX    = c_PRE_W'(CLK_HZ - 1);
   localparam logic [c_PSUM_W-1:0]       c_PEND_SAT   = c_PSUM_W'({PEND_W{1'b1}});
   localparam logic [4*SCORE_DIGITS-1:0] c_SCORE_FULL = {SCORE_DIGITS{4'h9}};
   localparam logic [4*TIME_DIGITS-1:0]  c_TIME_FULL  = {TIME_DIGITS{4'h9}};
   localparam logic [1:0] c_ST_PLAYING = 2'b01;
   localparam logic [1:0] c_ST_INIT    = 2'b11;

   logic [4*SCORE_DIGITS-1:0] r_score, r_high;
   logic [4*TIME_DIGITS-1:0]  r_time;
   logic [PEND_W-1:0]         r_pending;
   logic [c_PRE_W-1:0]        r_pre;
   logic                      r_new_record, r_sec_tick;

   logic                      w_playing, w_init, w_drain;
   logic [c_SUM_W-1:0]        w_hit_sum;
   logic [c_PSUM_W-1:0]       w_pend_sum;
   logic [PEND_W-1:0]         w_pend_nxt;
   logic [4*SCORE_DIGITS-1:0] w_score_inc, w_score_nxt;
   logic [4*TIME_DIGITS-1:0]  w_time_inc;
   logic                      w_score_carry, w_time_carry;
   logic                      w_score_gt, w_cmp_done;

   assign w_playing = (game_status == c_ST_PLAYING);
   assign w_init    = (game_status == c_ST_INIT);
   assign w_drain   = (r_pending != '0);

   always_comb begin
      w_hit_sum = '0;
      if (w_playing) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (apple_hit[i]) w_hit_sum = w_hit_sum + c_SUM_W'(CH_WEIGHTS[4*i +: 4]);
         end
      end
   end

   // Ripple decimal increment: each digit rolls 9->0 while the carry persists.
   always_comb begin
      w_score_inc   = r_score;
      w_score_carry = 1'b1;
      for (int d = 0; d < SCORE_DIGITS; d++) begin
         if (w_score_carry) begin
            if (r_score[4*d +: 4] == 4'd9) begin
               w_score_inc[4*d +: 4] = 4'd0;
            end else begin
               w_score_inc[4*d +: 4] = r_score[4*d +: 4] + 4'd1;
               w_score_carry         = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_time_inc   = r_time;
      w_time_carry = 1'b1;
      for (int d = 0; d < TIME_DIGITS; d++) begin
         if (w_time_carry) begin
            if (r_time[4*d +: 4] == 4'd9) begin
               w_time_inc[4*d +: 4] = 4'd0;
            end else begin
               w_time_inc[4*d +: 4] = r_time[4*d +: 4] + 4'd1;
               w_time_carry         = 1'b0;
            end
         end
      end
   end

   assign w_score_nxt = (w_drain && (r_score != c_SCORE_FULL)) ? w_score_inc : r_score;
   assign w_pend_sum  = c_PSUM_W'(r_pending) + c_PSUM_W'(w_hit_sum) - c_PSUM_W'(w_drain);

   // Once the score is pinned at all nines, any outstanding points are dropped.
   always_comb begin
      if (w_score_nxt == c_SCORE_FULL)  w_pend_nxt = '0;
      else if (w_pend_sum > c_PEND_SAT) w_pend_nxt = '1;
      else                              w_pend_nxt = w_pend_sum[PEND_W-1:0];
   end

   // Most-significant differing digit decides the magnitude comparison.
   always_comb begin
      w_score_gt = 1'b0;
      w_cmp_done = 1'b0;
      for (int d = SCORE_DIGITS - 1; d >= 0; d--) begin
         if (!w_cmp_done && (r_score[4*d +: 4] != r_high[4*d +: 4])) begin
            w_score_gt = (r_score[4*d +: 4] > r_high[4*d +: 4]);
            w_cmp_done = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_score      <= '0;
         r_high       <= '0;
         r_time       <= '0;
         r_pending    <= '0;
         r_pre        <= '0;
         r_new_record <= 1'b0;
         r_sec_tick   <= 1'b0;
      end else begin
         if (w_score_gt) begin
            r_high       <= r_score;
            r_new_record <= 1'b1;
         end
         if (w_init) begin
            r_score      <= '0;
            r_pending    <= '0;
            r_time       <= '0;
            r_pre        <= '0;
            r_new_record <= 1'b0;
            r_sec_tick   <= 1'b0;
         end else begin
            r_score    <= w_score_nxt;
            r_pending  <= w_pend_nxt;
            r_sec_tick <= 1'b0;
            if (w_playing) begin
               if (r_pre == c_PRE_MAX) begin
                  r_pre      <= '0;
                  r_sec_tick <= 1'b1;
                  if (r_time != c_TIME_FULL) r_time <= w_time_inc;
               end else begin
                  r_pre <= r_pre + 1'b1;
               end
            end
         end
      end
   end

   assign score_bcd  = r_score;
   assign high_bcd   = r_high;
   assign time_bcd   = r_time;
   assign busy       = w_drain;
   assign new_record = r_new_record;
   assign sec_tick   = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_tracker
// Description : Directed self-checking bench for score_tracker (CLK_HZ = 10).
// Revision    : 1.0  initial release
// ============================================================================
module tb_score_tracker;

   localparam logic [1:0] ST_LAUNCH = 2'b00;
   localparam logic [1:0] ST_PLAY   = 2'b01;
   localparam logic [1:0] ST_DIE    = 2'b10;
   localparam logic [1:0] ST_INIT   = 2'b11;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  apple_hit;
   logic [1:0]  game_status;
   logic [15:0] score_bcd, high_bcd, time_bcd;
   logic        busy, new_record, sec_tick;

   int checks = 0;
   int errors = 0;
   int ticks;

   score_tracker #(
      .NUM_CH(5), .CH_WEIGHTS(20'h11311), .SCORE_DIGITS(4),
      .TIME_DIGITS(4), .CLK_HZ(10), .PEND_W(8)
   ) dut (
      .clock(clock), .reset(reset), .apple_hit(apple_hit),
      .game_status(game_status), .score_bcd(score_bcd), .high_bcd(high_bcd),
      .time_bcd(time_bcd), .busy(busy), .new_record(new_record),
      .sec_tick(sec_tick)
   );

   always #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy === 1'b1 && n < bound) begin
         step(1);
         n++;
      end
      chk("idle_within_bound", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; apple_hit = '0; game_status = ST_INIT;
      #1;
      chk("rst_score", score_bcd, 0);
      chk("rst_high", high_bcd, 0);
      chk("rst_busy_nr_tick", {busy, new_record, sec_tick}, 0);
      step(2);
      reset = 1'b1;
      step(2);

      // Single weight-3 hit
      game_status = ST_PLAY; apple_hit = 5'b00100;
      step(1); apple_hit = '0;
      chk("k_busy", busy, 1);     chk("k_score", score_bcd, 16'h0000);
      step(1);
      chk("k1_busy", busy, 1);    chk("k1_score", score_bcd, 16'h0001);
      step(1);
      chk("k2_busy", busy, 1);    chk("k2_score", score_bcd, 16'h0002);
      step(1);
      chk("k3_busy", busy, 0);    chk("k3_score", score_bcd, 16'h0003);
      chk("k3_high_lag", high_bcd, 16'h0002);
      step(1);
      chk("k4_high", high_bcd, 16'h0003); chk("k4_newrec", new_record, 1);

      // INITIALIZING clears game state, keeps high score
      game_status = ST_INIT; step(1);
      chk("init1_score", score_bcd, 0);   chk("init1_time", time_bcd, 0);
      chk("init1_high", high_bcd, 16'h0003); chk("init1_newrec", new_record, 0);

      // All channels at once, then decimal carry
      game_status = ST_PLAY; apple_hit = 5'b11111; step(1);
      apple_hit = '0; step(7);
      chk("all_ch_score", score_bcd, 16'h0007); chk("all_ch_busy", busy, 0);
      apple_hit = 5'b00011; step(1); apple_hit = '0; step(2);
      chk("nine_score", score_bcd, 16'h0009);
      apple_hit = 5'b00011; step(1); apple_hit = '0; step(2);
      chk("carry_score", score_bcd, 16'h0011);
      step(1);
      chk("carry_high", high_bcd, 16'h0011); chk("carry_newrec", new_record, 1);

      // Hits outside PLAYING are ignored
      game_status = ST_DIE; apple_hit = 5'b11111; step(3);
      game_status = ST_LAUNCH; step(2); apple_hit = '0;
      chk("ignored_busy", busy, 0); chk("ignored_score", score_bcd, 16'h0011);

      // Draining continues after death
      game_status = ST_PLAY; apple_hit = 5'b11111; step(1);
      apple_hit = '0; game_status = ST_DIE; step(7);
      chk("die_drain_score", score_bcd, 16'h0018); chk("die_drain_busy", busy, 0);

      // Elapsed time: 25 PLAYING cycles then 20 DIE_FLASHING cycles
      game_status = ST_INIT; step(1);
      chk("init2_score", score_bcd, 0); chk("init2_high", high_bcd, 16'h0018);
      chk("init2_newrec", new_record, 0);
      game_status = ST_PLAY; ticks = 0;
      for (int i = 0; i < 25; i++) begin
         step(1);
         if (sec_tick === 1'b1) ticks++;
      end
      chk("play_time", time_bcd, 16'h0002); chk("play_ticks", ticks, 2);
      game_status = ST_DIE; ticks = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (sec_tick === 1'b1) ticks++;
      end
      chk("die_time", time_bcd, 16'h0002); chk("die_ticks", ticks, 0);
      game_status = ST_INIT; step(1);
      chk("init3_time", time_bcd, 0); chk("init3_score", score_bcd, 0);

      // Pending saturates at 255: 49 drains while hitting + 255 afterwards
      game_status = ST_PLAY; apple_hit = 5'b11111; step(50);
      apple_hit = '0; wait_idle(400);
      chk("pend_sat_score", score_bcd, 16'h0304);

      // Score saturation at 9999
      game_status = ST_INIT; step(1);
      game_status = ST_PLAY; apple_hit = 5'b00001; step(9998);
      apple_hit = '0; wait_idle(10);
      chk("pre_sat_score", score_bcd, 16'h9998);
      apple_hit = 5'b00100; step(1); apple_hit = '0;
      step(3);
      chk("sat_score", score_bcd, 16'h9999); chk("sat_busy", busy, 0);
      apple_hit = 5'b11111; step(1); apple_hit = '0;
      chk("sat_hit_busy", busy, 0);
      step(3);
      chk("sat_hold_score", score_bcd, 16'h9999); chk("sat_high", high_bcd, 16'h9999);

      // Reset mid-drain
      game_status = ST_INIT; step(1);
      game_status = ST_PLAY; apple_hit = 5'b00111; step(1); apple_hit = '0;
      chk("mid_busy", busy, 1);
      step(1);
      chk("mid_score", score_bcd, 16'h0001);
      reset = 1'b0; #1;
      chk("async_score", score_bcd, 0); chk("async_high", high_bcd, 0);
      chk("async_time", time_bcd, 0);
      chk("async_flags", {busy, new_record, sec_tick}, 0);
      step(2);
      reset = 1'b1;
      step(10);
      chk("post_rst_score", score_bcd, 0); chk("post_rst_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
